led_ctrl_mc: RTL and testbench
==============================

Name: led_ctrl_mc

Overview:
Multi-channel RGB LED controller that replaces fixed LED fan-out and the single-channel divider counter at the board top level. Each channel drives one 3-bit RGB LED in mode OFF, ON, BLINK (divider-based) or PWM (dimmed), with a configurable colour mask. Configuration arrives over a simple write strobe from PS/block-design logic. Out of reset every LED blinks white, so the board shows life with no software.

Parameters:
NUM_CH, 2, number of RGB channels (1..16)
CH_W, 1, width of ch_sel_i; must satisfy 2**CH_W >= NUM_CH
DIV_W, 5, width of blink divider field
PWM_W, 8, width of PWM duty field and PWM counter
PRESCALE, 100000, clk100 cycles per blink tick (>= 2)
RST_DIV, 10, per-channel div value after reset

Ports:
clk100  in  1  system clock
rstn  in  1  asynchronous active-low reset
wren_i  in  1  config write strobe, one transaction per high cycle
ch_sel_i  in  CH_W  channel to write
mode_i  in  2  0=OFF, 1=ON, 2=BLINK, 3=PWM
div_i  in  DIV_W  blink half-period, in ticks minus 1
duty_i  in  PWM_W  PWM on-count
color_i  in  3  RGB enable mask {R,G,B}
sync_i  in  1  restart all counters and phases (aligns blink across channels)
ack_o  out  1  1-cycle pulse: write accepted
err_o  out  1  1-cycle pulse: write rejected (ch_sel_i >= NUM_CH)
led_o  out  NUM_CH*3  channel n on bits [3n+2:3n]; registered

Behaviour:
- Reset (rstn low, asynchronous): led_o=0, ack_o=0, err_o=0, prescaler=0, all blink/PWM counters=0, all phases=0. Every channel resets to mode=BLINK, div=RST_DIV, duty=0, color=3'b111.
- Prescaler: counts 0..PRESCALE-1 on clk100. tick is high for one cycle when the count wraps to 0, i.e. once every PRESCALE cycles. The first tick occurs PRESCALE cycles after reset release.
- BLINK: per-channel tick counter. On a tick with count==div: count<=0 and the phase toggles; otherwise count increments. Period = 2*(div+1)*PRESCALE cycles. div=0 toggles on every tick. Output = phase ? color : 0.
- PWM: one shared free-running PWM_W counter, incremented every clk100 cycle and wrapping at 2**PWM_W-1 -> 0. Output = (pwm_cnt < duty) ? color : 0. duty=0 gives always off. duty=max gives on for (2**PWM_W-1) of 2**PWM_W cycles.
- ON: output = color. OFF: output = 0.
- led_o is registered. It reflects the current config and counters with 1 cycle of latency.
- Write: sampled on the clk100 edge where wren_i=1.
  - If ch_sel_i < NUM_CH: that channel's mode/div/duty/color are updated at that edge, and its blink count and phase clear to 0. ack_o pulses on the next cycle. led_o shows the new config one cycle after the config registers update.
  - Otherwise: no state changes and err_o pulses on the next cycle.
  - Back-to-back writes on consecutive cycles are all accepted, one ack each.
- sync_i=1 at an edge clears the prescaler, the PWM counter and all blink counts and phases. Config is not affected.
- wren_i and sync_i in the same cycle: both take effect. The written channel ends with count=0 and phase=0.
- A write arriving on a tick cycle for the same channel: the write wins; no toggle happens that cycle.
- Reducing div below the current count is impossible, because every write clears the count.
- rstn asserted mid-blink or mid-PWM returns the block to the reset state immediately. There is no partial-write effect.

Test Plan:
- Reset defaults (PRESCALE=4, RST_DIV=1): release rstn -> led_o=0 until the 2nd tick (cycle 8 + 1 latency), then led_o=6'b111111, toggling every 8 cycles.
- Mode ON, invalid channel: write ch0 mode=1 color=3'b100 -> ack_o pulses 1 cycle later, led_o[2:0]=3'b100 the following cycle, ch1 unchanged. Then write ch_sel=1 with NUM_CH=1 -> err_o pulses, no led_o change.
- PWM duty (PWM_W=8): ch1 mode=3 duty=64 color=3'b010 -> led_o[4] high for exactly 64 of every 256 cycles. duty=0 -> never high.
- Blink period: div=3, PRESCALE=4 -> phase toggles every 16 cycles, period 32. Then div=0 -> toggle every 4 cycles.
- sync_i: two channels blinking out of phase, pulse sync_i -> both phases 0 and both counts 0, identical waveforms afterwards. sync_i together with wren_i -> both effects applied, one ack.
- Async reset mid-operation: drop rstn between clock edges during PWM -> led_o goes to 0 without waiting for a clock edge, and the config returns to reset defaults.

Source files
------------

// File: rtl/led_ctrl_mc.sv
// led_ctrl_mc: multi-channel RGB LED controller (OFF / ON / BLINK / PWM).
// Ports: clk100, rstn (async low); write strobe wren_i with ch_sel_i,
//   mode_i, div_i, duty_i, color_i; sync_i restarts all counters;
//   ack_o / err_o one-cycle write responses; led_o registered, 3 bits/ch.
module led_ctrl_mc #(
  parameter int NUM_CH   = 2,
  parameter int CH_W     = 1,
  parameter int DIV_W    = 5,
  parameter int PWM_W    = 8,
  parameter int PRESCALE = 100000,
  parameter int RST_DIV  = 10
) (
  input  logic                clk100,
  input  logic                rstn,
  input  logic                wren_i,
  input  logic [CH_W-1:0]     ch_sel_i,
  input  logic [1:0]          mode_i,
  input  logic [DIV_W-1:0]    div_i,
  input  logic [PWM_W-1:0]    duty_i,
  input  logic [2:0]          color_i,
  input  logic                sync_i,
  output logic                ack_o,
  output logic                err_o,
  output logic [NUM_CH*3-1:0] led_o
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [CH_W:0] CH_LIM = (CH_W + 1)'(NUM_CH);

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2,
    MODE_PWM   = 2'd3
  } mode_e;

  typedef struct packed {
    mode_e            mode;
    logic [DIV_W-1:0] div;
    logic [PWM_W-1:0] duty;
    logic [2:0]       color;
  } ch_cfg_t;

  logic [PS_W-1:0]     pre_q;
  logic                tick;
  logic [PWM_W-1:0]    pwm_q;
  ch_cfg_t             cfg_q [NUM_CH];
  logic [DIV_W-1:0]    cnt_q [NUM_CH];
  logic [NUM_CH-1:0]   phase_q;
  logic                sel_ok;
  logic [NUM_CH-1:0]   hit;
  logic [NUM_CH*3-1:0] led_d;
  ch_cfg_t             wr_cfg;

  assign sel_ok = {1'b0, ch_sel_i} < CH_LIM;
  assign tick   = (pre_q == PS_LAST);

  always_comb begin
    wr_cfg.mode  = mode_e'(mode_i);
    wr_cfg.div   = div_i;
    wr_cfg.duty  = duty_i;
    wr_cfg.color = color_i;
  end

  always_comb begin
    hit = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      hit[i] = wren_i && sel_ok &&
               (ch_sel_i == CH_W'(i));
    end
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      pre_q <= '0;
    end else if (sync_i || tick) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_q + 1'b1;
    end
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      pwm_q <= '0;
    end else if (sync_i) begin
      pwm_q <= '0;
    end else begin
      pwm_q <= pwm_q + 1'b1;
    end
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      ack_o <= 1'b0;
      err_o <= 1'b0;
    end else begin
      ack_o <= wren_i && sel_ok;
      err_o <= wren_i && !sel_ok;
    end
  end

  // A write beats both sync and tick for its own channel.
  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      phase_q <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cfg_q[i].mode  <= MODE_BLINK;
        cfg_q[i].div   <= DIV_W'(RST_DIV);
        cfg_q[i].duty  <= '0;
        cfg_q[i].color <= 3'b111;
        cnt_q[i]       <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (hit[i]) begin
          cfg_q[i]   <= wr_cfg;
          cnt_q[i]   <= '0;
          phase_q[i] <= 1'b0;
        end else if (sync_i) begin
          cnt_q[i]   <= '0;
          phase_q[i] <= 1'b0;
        end else if (tick) begin
          if (cnt_q[i] == cfg_q[i].div) begin
            cnt_q[i]   <= '0;
            phase_q[i] <= ~phase_q[i];
          end else begin
            cnt_q[i] <= cnt_q[i] + 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    led_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      unique case (cfg_q[i].mode)
        MODE_OFF:   led_d[3*i +: 3] = 3'b000;
        MODE_ON:    led_d[3*i +: 3] = cfg_q[i].color;
        MODE_BLINK: led_d[3*i +: 3] =
          phase_q[i] ? cfg_q[i].color : 3'b000;
        MODE_PWM:   led_d[3*i +: 3] =
          (pwm_q < cfg_q[i].duty) ? cfg_q[i].color : 3'b000;
      endcase
    end
  end

  always_ff @(posedge clk100 or negedge rstn) begin
    if (!rstn) begin
      led_o <= '0;
    end else begin
      led_o <= led_d;
    end
  end

endmodule

// File: tb/tb_led_ctrl_mc.sv
// tb_led_ctrl_mc: directed bench for led_ctrl_mc.
// Two channels, PRESCALE=4, RST_DIV=1, invalid selects via CH_W=2.
module tb_led_ctrl_mc;

  logic       clk100 = 1'b0;
  logic       rstn = 1'b0;
  logic       wren_i = 1'b0;
  logic [1:0] ch_sel_i = '0;
  logic [1:0] mode_i = '0;
  logic [4:0] div_i = '0;
  logic [7:0] duty_i = '0;
  logic [2:0] color_i = '0;
  logic       sync_i = 1'b0;
  logic       ack_o;
  logic       err_o;
  logic [5:0] led_o;

  int n_checks = 0;
  int n_fail = 0;

  led_ctrl_mc #(
    .NUM_CH(2), .CH_W(2), .DIV_W(5),
    .PWM_W(8), .PRESCALE(4), .RST_DIV(1)
  ) dut (
    .clk100(clk100), .rstn(rstn),
    .wren_i(wren_i), .ch_sel_i(ch_sel_i),
    .mode_i(mode_i), .div_i(div_i),
    .duty_i(duty_i), .color_i(color_i),
    .sync_i(sync_i), .ack_o(ack_o),
    .err_o(err_o), .led_o(led_o)
  );

  always #5 clk100 = ~clk100;

  task automatic step();
    @(posedge clk100);
    #1;
  endtask

  task automatic apply_reset();
    rstn = 1'b0;
    wren_i = 1'b0;
    sync_i = 1'b0;
    step();
    step();
    rstn = 1'b1;
  endtask

  task automatic wr(input logic [1:0] ch, input logic [1:0] md,
                    input logic [4:0] dv, input logic [7:0] dt,
                    input logic [2:0] col, input logic sy);
    wren_i = 1'b1;
    ch_sel_i = ch;
    mode_i = md;
    div_i = dv;
    duty_i = dt;
    color_i = col;
    sync_i = sy;
    step();
    wren_i = 1'b0;
    sync_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [5:0] exp;
    rstn = 1'b0;
    step();
    n_checks++;
    if (led_o !== 6'd0 || ack_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold: led=%b ack=%b err=%b want 0",
               led_o, ack_o, err_o);
    end
    rstn = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      step();
      exp = (((k - 1) / 8) % 2 == 1) ? 6'h3f : 6'h00;
      n_checks++;
      if (led_o !== exp) begin
        n_fail++;
        $display("FAIL reset_blink k=%0d: led=%b want %b",
                 k, led_o, exp);
      end
    end
  endtask

  task automatic test_on_invalid();
    apply_reset();
    wr(2'd0, 2'd1, 5'd0, 8'd0, 3'b100, 1'b0);
    n_checks++;
    if (ack_o !== 1'b1 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL on_ack: ack=%b err=%b want 1 0", ack_o, err_o);
    end
    step();
    n_checks++;
    if (led_o !== 6'b000100 || ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL on_led: led=%b ack=%b want 000100 0",
               led_o, ack_o);
    end
    for (int c = 2; c <= 3; c++) begin
      wr(2'(c), 2'd1, 5'd0, 8'd0, 3'b111, 1'b0);
      n_checks++;
      if (err_o !== 1'b1 || ack_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_sel_err ch=%0d: err=%b ack=%b want 1 0",
                 c, err_o, ack_o);
      end
      step();
      n_checks++;
      if (led_o !== 6'b000100 || err_o !== 1'b0) begin
        n_fail++;
        $display("FAIL bad_sel_led ch=%0d: led=%b err=%b want 000100 0",
                 c, led_o, err_o);
      end
    end
  endtask

  task automatic pwm_window(input logic [7:0] duty, input int exp_on);
    int on_g;
    int on_rb;
    on_g = 0;
    on_rb = 0;
    wr(2'd1, 2'd3, 5'd0, duty, 3'b010, 1'b0);
    for (int k = 0; k < 256; k++) begin
      step();
      if (led_o[4]) on_g++;
      if (led_o[3] || led_o[5]) on_rb++;
    end
    n_checks++;
    if (on_g !== exp_on) begin
      n_fail++;
      $display("FAIL pwm_duty duty=%0d: on=%0d want %0d",
               duty, on_g, exp_on);
    end
    n_checks++;
    if (on_rb !== 0) begin
      n_fail++;
      $display("FAIL pwm_mask duty=%0d: rb_on=%0d want 0", duty, on_rb);
    end
  endtask

  task automatic test_pwm();
    apply_reset();
    pwm_window(8'd64, 64);
    pwm_window(8'd0, 0);
    pwm_window(8'd255, 255);
  endtask

  task automatic test_blink();
    logic [2:0] exp;
    apply_reset();
    wr(2'd0, 2'd2, 5'd3, 8'd0, 3'b111, 1'b1);
    n_checks++;
    if (ack_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sync_wr_ack: ack=%b want 1", ack_o);
    end
    for (int k = 2; k <= 50; k++) begin
      step();
      if (k == 2) begin
        n_checks++;
        if (ack_o !== 1'b0) begin
          n_fail++;
          $display("FAIL sync_wr_single_ack: ack=%b want 0", ack_o);
        end
      end
      exp = (((k - 2) / 16) % 2 == 1) ? 3'b111 : 3'b000;
      n_checks++;
      if (led_o[2:0] !== exp) begin
        n_fail++;
        $display("FAIL blink_div3 k=%0d: led=%b want %b",
                 k, led_o[2:0], exp);
      end
    end
    wr(2'd0, 2'd2, 5'd0, 8'd0, 3'b111, 1'b1);
    for (int k = 2; k <= 20; k++) begin
      step();
      exp = (k >= 6 && ((k - 6) / 4) % 2 == 0) ? 3'b111 : 3'b000;
      n_checks++;
      if (led_o[2:0] !== exp) begin
        n_fail++;
        $display("FAIL blink_div0 k=%0d: led=%b want %b",
                 k, led_o[2:0], exp);
      end
    end
  endtask

  task automatic test_sync();
    logic [5:0] exp;
    apply_reset();
    wr(2'd0, 2'd2, 5'd1, 8'd0, 3'b111, 1'b1);
    for (int k = 2; k <= 4; k++) step();
    wr(2'd1, 2'd2, 5'd1, 8'd0, 3'b111, 1'b0);
    for (int k = 6; k <= 10; k++) step();
    n_checks++;
    if (led_o !== 6'b000111) begin
      n_fail++;
      $display("FAIL sync_pre_phase: led=%b want 000111", led_o);
    end
    for (int k = 11; k <= 19; k++) step();
    sync_i = 1'b1;
    step();
    sync_i = 1'b0;
    n_checks++;
    if (ack_o !== 1'b0) begin
      n_fail++;
      $display("FAIL sync_no_ack: ack=%b want 0", ack_o);
    end
    for (int j = 1; j <= 40; j++) begin
      step();
      exp = (j >= 9 && ((j - 9) / 8) % 2 == 0) ? 6'h3f : 6'h00;
      n_checks++;
      if (led_o !== exp) begin
        n_fail++;
        $display("FAIL sync_align j=%0d: led=%b want %b", j, led_o, exp);
      end
    end
  endtask

  task automatic test_async_reset();
    logic [5:0] exp;
    apply_reset();
    wr(2'd1, 2'd3, 5'd0, 8'd128, 3'b111, 1'b0);
    step();
    step();
    n_checks++;
    if (led_o[5:3] !== 3'b111) begin
      n_fail++;
      $display("FAIL arst_pwm_on: led=%b want 111", led_o[5:3]);
    end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++;
    if (led_o !== 6'd0 || ack_o !== 1'b0 || err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_immediate: led=%b ack=%b err=%b want 0",
               led_o, ack_o, err_o);
    end
    #1;
    rstn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      exp = (((k - 1) / 8) % 2 == 1) ? 6'h3f : 6'h00;
      n_checks++;
      if (led_o !== exp) begin
        n_fail++;
        $display("FAIL arst_defaults k=%0d: led=%b want %b",
                 k, led_o, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_on_invalid();
    test_pwm();
    test_blink();
    test_sync();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
